// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and flag bundle for the decode path and execute stage.
package alu_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: one shared adder serves ADD, SUB and SLT; logic ops bypass it.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output alu_flags_t      flags,
    output logic            illegal
);
    logic            subtract;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] logic_res;
    alu_flags_t      arith_flags;

    assign subtract = (alu_control == ALU_SUB) || (alu_control == ALU_SLT);
    assign b_eff    = subtract ? ~b : b;
    assign sum      = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, subtract};

    // Signed overflow: operands agree in sign but the sum does not.
    assign arith_flags.n = sum[XLEN-1];
    assign arith_flags.z = (sum[XLEN-1:0] == '0);
    assign arith_flags.c = sum[XLEN];
    assign arith_flags.v = (a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);

    always_comb begin
        result    = '0;
        flags     = '0;
        illegal   = 1'b0;
        logic_res = (alu_control == ALU_AND) ? (a & b) : (a | b);
        case (alu_control)
            ALU_ADD, ALU_SUB: begin
                result = sum[XLEN-1:0];
                flags  = arith_flags;
            end
            ALU_SLT: begin
                result = {{(XLEN-1){1'b0}}, arith_flags.n ^ arith_flags.v};
                flags  = arith_flags;
            end
            ALU_AND, ALU_OR: begin
                result  = logic_res;
                flags.n = logic_res[XLEN-1];
                flags.z = (logic_res == '0);
            end
            default: begin
                illegal = 1'b1;
                flags.z = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/alu_execute_stage.sv
// Registered ALU execute stage with valid/ready on both sides and a 1-entry skid buffer.
module alu_execute_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_control,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [RD_W-1:0] rd_in,
    input  logic            reg_write_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            negative,
    output logic            carry,
    output logic            overflow,
    output logic            illegal_op,
    output logic [RD_W-1:0] rd_out,
    output logic            reg_write_out
);
    localparam int ENT_W = XLEN + 5 + RD_W + 1;

    logic [XLEN-1:0]  core_result;
    alu_flags_t       core_flags;
    logic             core_illegal;
    logic [ENT_W-1:0] core_ent, out_ent, skid_ent;
    logic             skid_valid, skid_valid_next, out_valid_next;
    logic             in_fire, out_open, out_load, skid_load;

    alu_core #(.XLEN(XLEN)) u_core (
        .alu_control (alu_control),
        .a           (src_a),
        .b           (src_b),
        .result      (core_result),
        .flags       (core_flags),
        .illegal     (core_illegal)
    );

    assign core_ent = {core_result, core_flags.n, core_flags.z, core_flags.c, core_flags.v,
                       core_illegal, rd_in, reg_write_in & ~core_illegal};
    assign {result, negative, zero, carry, overflow, illegal_op, rd_out, reg_write_out} = out_ent;

    // in_ready is a register equal to !skid_valid, so no input is taken while the skid is full.
    assign in_fire   = in_valid & in_ready;
    assign out_open  = !out_valid || out_ready;
    assign out_load  = !flush && out_open && (skid_valid || in_fire);
    assign skid_load = !flush && in_fire && out_valid && !out_ready;

    always_comb begin
        out_valid_next  = out_valid;
        skid_valid_next = skid_valid;
        if (flush) begin
            out_valid_next  = 1'b0;
            skid_valid_next = 1'b0;
        end else if (out_open) begin
            out_valid_next  = skid_valid || in_fire;
            skid_valid_next = 1'b0;
        end else if (in_fire) begin
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            out_ent    <= '0;
        end else begin
            out_valid  <= out_valid_next;
            skid_valid <= skid_valid_next;
            in_ready   <= !skid_valid_next;
            if (out_load)
                out_ent <= skid_valid ? skid_ent : core_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (skid_load)
            skid_ent <= core_ent;
    end
endmodule
